// File: rtl/alu_share_pkg.sv
// Shared types and widths for the alu sharing controller and its helpers.
package alu_share_pkg;

  localparam int unsigned ALU_W = 24;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_AND = 2'd1,
    OP_SHR = 2'd2,
    OP_SHL = 2'd3
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/alu.sv
// 24-bit combinational alu: ADD (wrapping), AND, logical SHR, SHL.
module alu
  import alu_share_pkg::*;
(
  input  alu_op_t          op_i,
  input  logic [ALU_W-1:0] a_i,
  input  logic [ALU_W-1:0] b_i,
  output logic [ALU_W-1:0] y_o
);

  // Shifts take the full b operand, so any amount >= ALU_W yields zero.
  always_comb begin
    y_o = '0;
    unique case (op_i)
      OP_ADD: y_o = a_i + b_i;
      OP_AND: y_o = a_i & b_i;
      OP_SHR: y_o = a_i >> b_i;
      OP_SHL: y_o = a_i << b_i;
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above ptr_i, wrapping.
module alu_rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  input  logic          en_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o
);

  always_comb begin
    logic          found;
    int unsigned   c;
    logic [IW-1:0] ci;
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    c       = 0;
    ci      = '0;
    for (int unsigned i = 0; i < N; i++) begin
      c = int'(ptr_i) + i;
      if (c >= N) c = c - N;
      ci = IW'(c);
      if (en_i && !found && req_i[ci]) begin
        found       = 1'b1;
        grant_o[ci] = 1'b1;
        idx_o       = ci;
      end
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin sharing of one alu among NUM_REQ valid/ready requesters.
// Optional per-requester grant counters when ALU_SHARE_STATS_EN is defined.
module alu_share_ctrl
  import alu_share_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0][1:0]         req_op,
  input  logic [NUM_REQ-1:0][ALU_W-1:0]   req_a,
  input  logic [NUM_REQ-1:0][ALU_W-1:0]   req_b,
  output logic [NUM_REQ-1:0]              resp_valid,
  input  logic [NUM_REQ-1:0]              resp_ready,
  output logic [ALU_W-1:0]                resp_r,
  output logic                            busy
`ifdef ALU_SHARE_STATS_EN
  ,
  output logic [NUM_REQ-1:0][CNT_W-1:0]   grant_cnt
`endif
);

  localparam int unsigned PW = $clog2(NUM_REQ);

  ctrl_state_t      state_q, state_d;
  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]    gnt_q, gnt_d;
  alu_op_t          op_q, op_d;
  logic [ALU_W-1:0] a_q, a_d;
  logic [ALU_W-1:0] b_q, b_d;
  logic [ALU_W-1:0] result_q, result_d;

  logic [NUM_REQ-1:0] arb_grant;
  logic [PW-1:0]      arb_idx;
  logic [ALU_W-1:0]   alu_y;

  alu_rr_arbiter #(
    .N  (NUM_REQ),
    .IW (PW)
  ) u_arb (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .en_i    (state_q == IDLE),
    .grant_o (arb_grant),
    .idx_o   (arb_idx)
  );

  // The alu only ever sees the latched operands, never live request inputs.
  alu u_alu (
    .op_i (op_q),
    .a_i  (a_q),
    .b_i  (b_q),
    .y_o  (alu_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    gnt_d      = gnt_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    result_d   = result_q;
    resp_valid = '0;
    unique case (state_q)
      IDLE: begin
        if (|arb_grant) begin
          gnt_d   = arb_idx;
          op_d    = alu_op_t'(req_op[arb_idx]);
          a_d     = req_a[arb_idx];
          b_d     = req_b[arb_idx];
          state_d = EXEC;
        end
      end
      EXEC: begin
        result_d = alu_y;
        state_d  = RESP;
      end
      RESP: begin
        resp_valid[gnt_q] = 1'b1;
        if (resp_ready[gnt_q]) begin
          rr_ptr_d = (gnt_q == PW'(NUM_REQ - 1)) ? '0 : gnt_q + PW'(1);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready = arb_grant;
  assign resp_r    = result_q;
  assign busy      = (state_q != IDLE);

`ifdef ALU_SHARE_STATS_EN
  logic [NUM_REQ-1:0][CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i] && (cnt_q[i] != '1)) begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign grant_cnt = cnt_q;
`endif

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
Shares the single 24-bit combinational alu (ops: 0 ADD, 1 AND, 2 SHR, 3 SHL) between NUM_REQ requesters. Each requester uses a valid/ready request channel and a valid/ready response channel. The controller arbitrates round-robin, registers operands, drives the alu for one cycle, captures the result, and returns it to the winning requester. It sits between execution clients and the alu instance, which it owns.

Parameters:
NUM_REQ, 4, number of requesters; legal range 2..8.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  reset, asynchronous, active-low.
req_valid  input  NUM_REQ  per-requester request valid.
req_ready  output  NUM_REQ  per-requester request accept; one-hot or zero.
req_op  input  NUM_REQ x 2  per-requester alu opcode.
req_a  input  NUM_REQ x 24  per-requester operand a.
req_b  input  NUM_REQ x 24  per-requester operand b.
resp_valid  output  NUM_REQ  per-requester result valid; one-hot or zero.
resp_ready  input  NUM_REQ  per-requester result accept.
resp_r  output  24  shared result bus; meaningful only when some resp_valid bit is set.
busy  output  1  high in EXEC and RESP.

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, req_ready=0, resp_valid=0, resp_r=0, busy=0, operand/op/grant registers=0.
- Reset asserted mid-operation: the transaction is dropped silently and no response is emitted. rr_ptr returns to 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - The arbiter picks the first asserted req_valid, searching upward from rr_ptr with wrap at NUM_REQ-1 -> 0.
  - req_ready[g] is driven combinationally high for the winner only, in that same cycle.
  - On the clock edge, the controller latches op/a/b and g, then goes to EXEC.
  - No valid requests: stays in IDLE; req_ready=0.
- EXEC:
  - The alu inputs are driven from the latched registers only, never from live request inputs.
  - The alu output is registered into result_q; the FSM goes to RESP.
- RESP:
  - resp_valid[g]=1 and resp_r=result_q.
  - Both are held stable until resp_ready[g]=1. Then rr_ptr = (g+1) mod NUM_REQ and the FSM goes to IDLE.
  - req_ready=0 throughout EXEC and RESP.
- Latency and throughput:
  - A request accepted at edge T gives resp_valid high from the cycle after edge T+1.
  - Minimum 3 cycles per transaction, with resp_ready tied high.
- Requester rules:
  - A requester must hold its req_* stable while req_valid is high and unaccepted.
  - Dropping req_valid before acceptance is legal; the arbiter re-evaluates every IDLE cycle.
- Arithmetic (alu semantics, 24-bit):
  - ADD wraps modulo 2^24.
  - AND is bitwise.
  - SHR is logical.
  - SHL discards bits shifted out.
  - Shift amount is the full b value; b >= 24 gives 0.
- Fairness: a requester asserting valid continuously is granted within NUM_REQ transactions.

Optional Feature:
Macro: ALU_SHARE_STATS_EN.
- With the macro defined:
  - Adds output grant_cnt, NUM_REQ x 16, one saturating counter per requester.
  - A counter increments on each accepted request (req_valid & req_ready), saturates at 16'hFFFF, and resets to 0.
- Without it: the port and the counters are absent; all other behaviour is identical.

Decomposition:
- Shared package alu_share_pkg:
  - localparam ALU_W=24.
  - typedef enum logic[1:0] alu_op_t {OP_ADD=0, OP_AND=1, OP_SHR=2, OP_SHL=3}.
  - typedef enum ctrl_state_t {IDLE, EXEC, RESP}.
- The existing alu is instantiated unchanged.
- One new sub-module, alu_rr_arbiter:
  - Inputs: req vector, rr_ptr, enable.
  - Outputs: one-hot grant and encoded index. Purely combinational.

Test Plan:
1. Single request, requester 0: op=0, a=5, b=11, resp_ready=1 -> req_ready[0] pulses 1 cycle; resp_valid[0] at cycle 3; resp_r=16; busy high for 2 cycles.
2. All four requesters valid, distinct ops (1: a=29 b=11; 2: a=48 b=3; 3: a=29 b=2) -> grants in order 0,1,2,3; results 9, 6, 116; rr_ptr wraps to 0.
3. Backpressure: resp_ready[1]=0 for 5 cycles -> resp_valid[1] and resp_r held stable; no new req_ready until accepted.
4. Boundaries: ADD a=24'hFFFFFF b=1 -> 0; SHL a=1 b=24 -> 0; SHR a=24'h800000 b=23 -> 1.
5. rst_n low during EXEC -> outputs return to reset values immediately; no resp_valid after release; the next grant starts from requester 0.
6. With ALU_SHARE_STATS_EN: requester 2 issues 3 requests -> grant_cnt[2]=3, others 0; counter preloaded near max saturates at 16'hFFFF.
